// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported unified memory between the fetch stage
//   (read-only) and the memory stage (read/write) of a pipelined ARM core.
//   Requests are sampled only in IDLE and granted one at a time. The winning
//   transaction runs IDLE -> WAIT -> RESP -> IDLE, so every transaction
//   occupies at least three cycles.
//
//   Data-stage requests normally win. A starvation counter forces a fetch
//   grant after STARVE_LIMIT consecutive lost arbitrations. A watchdog aborts
//   a WAIT that never sees m_ack. The aborted requester still gets its ack,
//   with err raised alongside it and its read data forced to zero.
//
// Parameters:
//   DATA_WIDTH   - width of addresses, write data and read data
//   STARVE_LIMIT - fetch losses tolerated before fetch is forced (1..15)
//   TIMEOUT      - WAIT cycles without m_ack before abort (0 = no watchdog)
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   f_req/f_addr      - fetch read request and address (held until f_ack)
//   f_rdata/f_ack     - fetch read data (held) and one-cycle completion
//   d_req/d_we/d_addr/d_wdata - data request, direction, address, store data
//   d_rdata/d_ack     - load data (held) and one-cycle completion
//   m_req/m_we/m_addr/m_wdata - memory-side request (held until ack/abort)
//   m_rdata/m_ack     - memory read data and completion
//   err               - one-cycle pulse alongside the ack of an aborted access
//   busy              - high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [DATA_WIDTH-1:0] f_addr,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack,
  output logic                  err,
  output logic                  busy
);

  // The timeout counter must be able to hold the value TIMEOUT itself; the +2
  // keeps the width at least one bit when the watchdog is disabled.
  localparam int unsigned           TMO_W      = $clog2(TIMEOUT + 2);
  localparam logic [TMO_W-1:0]      TMO_LIMIT  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0]      TMO_ONE    = TMO_W'(1);
  localparam bit                    TMO_EN     = (TIMEOUT != 0);
  localparam logic [3:0]            STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Saturating increment for the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] value,
                                         input logic [3:0] limit);
    logic [3:0] result;
    if (value >= limit) begin
      result = limit;
    end else begin
      result = value + 4'd1;
    end
    return result;
  endfunction

  state_e                  state_q,   state_d;
  logic                    grant_data_q, grant_data_d;  // 1 = data stage owns the access
  logic [3:0]              starve_q,  starve_d;
  logic [TMO_W-1:0]        tmo_q,     tmo_d;
  logic                    m_req_q,   m_req_d;
  logic                    m_we_q,    m_we_d;
  logic [DATA_WIDTH-1:0]   m_addr_q,  m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_WIDTH-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    f_ack_q,   f_ack_d;
  logic                    d_ack_q,   d_ack_d;
  logic                    err_q,     err_d;
  logic                    busy_q,    busy_d;

  logic                    grant_data_s;
  logic [TMO_W-1:0]        tmo_inc_s;

  assign tmo_inc_s = tmo_q + TMO_ONE;

  // Next-state logic: arbitration, memory handshake, watchdog and responses.
  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    grant_data_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Data wins by default; a starved fetch takes over when both request.
        grant_data_s = d_req && !(f_req && (starve_q == STARVE_MAX));

        if (f_req || d_req) begin
          grant_data_d = grant_data_s;
          m_req_d      = 1'b1;
          state_d      = ST_WAIT;
          if (grant_data_s) begin
            m_addr_d  = d_addr;
            m_we_d    = d_we;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = f_addr;
            m_we_d    = 1'b0;
            m_wdata_d = {DATA_WIDTH{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end

        // Count only arbitrations fetch actually lost; anything else clears.
        if (f_req && grant_data_s) begin
          starve_d = sat_inc(starve_q, STARVE_MAX);
        end else begin
          starve_d = 4'd0;
        end
      end

      ST_WAIT: begin
        // m_ack takes precedence over an expiring watchdog in the same cycle.
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = ST_RESP;
          if (grant_data_q) begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = m_rdata;
          end
        end else if (TMO_EN && (tmo_inc_s == TMO_LIMIT)) begin
          m_req_d = 1'b0;
          state_d = ST_RESP;
          err_d   = 1'b1;
          tmo_d   = tmo_inc_s;
          if (grant_data_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = {DATA_WIDTH{1'b0}};
          end
        end else if (TMO_EN) begin
          tmo_d = tmo_inc_s;
        end else begin
          tmo_d = tmo_q;
        end
      end

      ST_RESP: begin
        // The ack pulse is already on the outputs during this cycle.
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
        tmo_d   = {TMO_W{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_data_q <= 1'b0;
      starve_q     <= 4'd0;
      tmo_q        <= {TMO_W{1'b0}};
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= {DATA_WIDTH{1'b0}};
      m_wdata_q    <= {DATA_WIDTH{1'b0}};
      f_rdata_q    <= {DATA_WIDTH{1'b0}};
      d_rdata_q    <= {DATA_WIDTH{1'b0}};
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (read/write) of the pipelined ARM core.
- Serialises requests, drives the external memory handshake, and returns read data plus a one-cycle ack to the winning requester.
- Data-stage requests win by default; a starvation guard forces a fetch grant after repeated losses.
- A watchdog aborts memory accesses that never acknowledge and flags an error.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- STARVE_LIMIT, 4, consecutive arbitrations fetch may lose before it gets forced priority (1..15).
- TIMEOUT, 16, WAIT cycles without m_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request; hold until f_ack.
- f_addr  in  DATA_WIDTH  fetch address; stable while f_req high.
- f_rdata  out  DATA_WIDTH  fetch read data; valid with f_ack, held until the next fetch completion.
- f_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; hold until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; valid with d_ack, held until the next data completion.
- d_ack  out  1  one-cycle data completion pulse.
- m_req  out  1  memory request; held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_addr  out  DATA_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_rdata  in  DATA_WIDTH  memory read data; valid when m_ack is high.
- m_ack  in  1  memory completion; sampled only while m_req is high.
- err  out  1  one-cycle pulse, coincident with the ack of an aborted transaction.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; all outputs = 0; f_rdata = d_rdata = 0; starvation and timeout counters = 0.
- Reset mid-transaction drops it silently: no ack and no err are issued.
- All outputs are registered.

State machine: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: requests are sampled only in this state.
  - If any request is high, select a winner.
  - Latch the winner's address, we and wdata into m_addr/m_we/m_wdata (fetch forces m_we = 0).
  - Set m_req = 1 and go to WAIT.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: d wins, unless the starvation counter equals STARVE_LIMIT; then f wins.
  - Starvation counter: +1 when f_req is high and d wins; cleared when f wins or when f_req is low in IDLE; saturates at STARVE_LIMIT.
- WAIT:
  - m_ack high: m_req = 0. On a read, capture m_rdata into the winner's rdata register. Go to RESP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT (nonzero), m_req = 0, the winner's rdata = 0, the err flag is armed, and the state goes to RESP.
  - m_ack in the same cycle the counter hits TIMEOUT: the ack wins and no error is raised.
- RESP: pulse the winner's ack for one cycle (err too if armed). Clear the timeout counter. Go to IDLE.
- Requester rule: by the clock edge ending its ack cycle, the requester must drop req or present a new request. Requests are never sampled in RESP, so a stale req is never regranted.
- Latency: request seen in IDLE at cycle 0 -> m_req high in cycle 1.
  - m_ack in cycle 1 -> ack in cycle 2.
  - Minimum occupancy is 3 cycles per transaction.
- m_ack while m_req is low (IDLE/RESP): ignored.
- f_ack and d_ack are never high together.
- m_req never rises in the cycle after it falls.
- Writes leave d_rdata unchanged.

Test Plan:
- Single fetch: f_req = 1, f_addr = 0x100; memory acks in 1 cycle with 0xE3A00001 -> m_req high cycle 1, f_ack and f_rdata = 0xE3A00001 in cycle 2, busy high in cycles 1-2.
- Contention: f_req and d_req both high continuously, memory acks immediately -> grant order d,d,d,d,f,d,d,d,d,f (STARVE_LIMIT = 4), f_ack every 5th completion.
- Store: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, m_ack after 3 cycles -> m_we = 1 with matching m_addr/m_wdata, d_ack 1 cycle after m_ack, d_rdata unchanged.
- Timeout: TIMEOUT = 16, memory never acks -> m_req drops after 16 WAIT cycles; next cycle d_ack = 1, err = 1, d_rdata = 0; then a normal fetch completes correctly.
- Race: m_ack asserted in exactly the 16th WAIT cycle -> normal ack, err = 0, rdata = m_rdata.
- Reset mid-WAIT: reset low for 1 cycle during WAIT -> m_req, busy and all acks drop immediately; no ack is ever issued for the dropped request; the next request proceeds normally.
